// File: rtl/dma_channel_engine.sv
// Single-channel 8237-style DMA engine: moves one byte (or word) per device request through the arbiter's DMA master port.
// Word transfers are compiled in with `define DMA_WORD_MODE_EN, which adds the cfg_word input.
module dma_channel_engine #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [19:0]        cfg_addr,
   input  logic [COUNT_W-1:0] cfg_count,
   input  logic               cfg_dir,
   input  logic               cfg_decrement,
   input  logic               cfg_autoinit,
   input  logic               cfg_start,
   input  logic               cfg_stop,
`ifdef DMA_WORD_MODE_EN
   input  logic               cfg_word,
`endif
   input  logic               dreq,
   output logic               dack,
   input  logic [15:0]        dev_rd_data,
   output logic [15:0]        dev_wr_data,
   output logic               dev_strobe,
   output logic               tc,
   output logic               busy,
   output logic [18:0]        m_addr,
   input  logic [15:0]        m_data_in,
   output logic [15:0]        m_data_out,
   output logic               m_access,
   input  logic               m_ack,
   output logic               m_wr_en,
   output logic [1:0]         m_bytesel
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_REQ,
      S_BUS,
      S_XFER,
      S_COMPLETE
   } state_t;

   state_t               state_q, state_d;
   logic [19:0]          addr_q, addr_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 dir_q, dir_d;
   logic                 dec_q, dec_d;
   logic                 auto_q, auto_d;
   logic                 word_q, word_d;
   logic                 stop_q, stop_d;
   logic                 dack_q, dack_d;
   logic [15:0]          dev_wr_q, dev_wr_d;
   logic                 strobe_q, strobe_d;
   logic                 tc_q, tc_d;
   logic                 busy_q, busy_d;
   logic [18:0]          m_addr_q, m_addr_d;
   logic [15:0]          m_dout_q, m_dout_d;
   logic                 m_acc_q, m_acc_d;
   logic                 m_wr_q, m_wr_d;
   logic [1:0]           m_bs_q, m_bs_d;

   logic                 word_sel;
   logic [19:0]          step;
   logic                 stop_now;
   logic                 unused_rd_hi;

`ifdef DMA_WORD_MODE_EN
   assign word_sel = cfg_word;
`else
   assign word_sel = 1'b0;
`endif

   assign step         = word_q ? 20'd2 : 20'd1;
   assign stop_now     = stop_q | cfg_stop;
   assign unused_rd_hi = ^dev_rd_data[15:8];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         dec_q    <= 1'b0;
         auto_q   <= 1'b0;
         word_q   <= 1'b0;
         stop_q   <= 1'b0;
         dack_q   <= 1'b0;
         dev_wr_q <= '0;
         strobe_q <= 1'b0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         m_addr_q <= '0;
         m_dout_q <= '0;
         m_acc_q  <= 1'b0;
         m_wr_q   <= 1'b0;
         m_bs_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         dec_q    <= dec_d;
         auto_q   <= auto_d;
         word_q   <= word_d;
         stop_q   <= stop_d;
         dack_q   <= dack_d;
         dev_wr_q <= dev_wr_d;
         strobe_q <= strobe_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
         m_addr_q <= m_addr_d;
         m_dout_q <= m_dout_d;
         m_acc_q  <= m_acc_d;
         m_wr_q   <= m_wr_d;
         m_bs_q   <= m_bs_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      count_d  = count_q;
      dir_d    = dir_q;
      dec_d    = dec_q;
      auto_d   = auto_q;
      word_d   = word_q;
      stop_d   = stop_q;
      dack_d   = dack_q;
      dev_wr_d = dev_wr_q;
      strobe_d = 1'b0;
      tc_d     = 1'b0;
      busy_d   = busy_q;
      m_addr_d = m_addr_q;
      m_dout_d = m_dout_q;
      m_acc_d  = m_acc_q;
      m_wr_d   = m_wr_q;
      m_bs_d   = m_bs_q;

      unique case (state_q)
         S_IDLE: begin
            if (cfg_start && !cfg_stop) begin
               addr_d  = word_sel ? {cfg_addr[19:1], 1'b0} : cfg_addr;
               count_d = cfg_count;
               dir_d   = cfg_dir;
               dec_d   = cfg_decrement;
               auto_d  = cfg_autoinit;
               word_d  = word_sel;
               stop_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_WAIT_REQ;
            end
         end
         S_WAIT_REQ: begin
            if (cfg_stop) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (dreq) begin
               dack_d   = 1'b1;
               m_acc_d  = 1'b1;
               m_addr_d = addr_q[19:1];
               m_bs_d   = word_q ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);
               m_wr_d   = ~dir_q;
               // Device->memory data is captured and strobed on the same edge dack rises.
               if (!dir_q) begin
                  strobe_d = 1'b1;
                  m_dout_d = word_q ? dev_rd_data : {2{dev_rd_data[7:0]}};
               end
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            if (cfg_stop) stop_d = 1'b1;
            if (m_ack) begin
               m_acc_d = 1'b0;
               m_wr_d  = 1'b0;
               if (stop_now) begin
                  dack_d  = 1'b0;
                  busy_d  = 1'b0;
                  stop_d  = 1'b0;
                  state_d = S_IDLE;
               end else if (dir_q) begin
                  dev_wr_d = word_q ? m_data_in
                                    : {8'h00, (addr_q[0] ? m_data_in[15:8] : m_data_in[7:0])};
                  strobe_d = 1'b1;
                  state_d  = S_XFER;
               end else begin
                  state_d = S_COMPLETE;
               end
            end
         end
         S_XFER: begin
            if (cfg_stop) stop_d = 1'b1;
            state_d = S_COMPLETE;
         end
         S_COMPLETE: begin
            dack_d = 1'b0;
            if (stop_now) begin
               busy_d  = 1'b0;
               stop_d  = 1'b0;
               state_d = S_IDLE;
            end else if (count_q == '0) begin
               tc_d = 1'b1;
               if (auto_q) begin
                  addr_d  = word_q ? {cfg_addr[19:1], 1'b0} : cfg_addr;
                  count_d = cfg_count;
                  state_d = S_WAIT_REQ;
               end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               addr_d  = dec_q ? (addr_q - step) : (addr_q + step);
               count_d = count_q - COUNT_W'(1);
               state_d = S_WAIT_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dack        = dack_q;
   assign dev_wr_data = dev_wr_q;
   assign dev_strobe  = strobe_q;
   assign tc          = tc_q;
   assign busy        = busy_q;
   assign m_addr      = m_addr_q;
   assign m_data_out  = m_dout_q;
   assign m_access    = m_acc_q;
   assign m_wr_en     = m_wr_q;
   assign m_bytesel   = m_bs_q;

endmodule

// File: tb/tb_dma_channel_engine.sv
// Self-checking bench for dma_channel_engine: bus responder, device model and an address/data reference model.
`timescale 1ns/1ps
module tb_dma_channel_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [19:0] cfg_addr = '0;
   logic [15:0] cfg_count = '0;
   logic        cfg_dir = 1'b0, cfg_decrement = 1'b0, cfg_autoinit = 1'b0;
   logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_word = 1'b0;
   logic        dreq = 1'b0;
   logic        dack;
   logic [15:0] dev_rd_data = 16'h5A3C;
   logic [15:0] dev_wr_data;
   logic        dev_strobe, tc, busy;
   logic [18:0] m_addr;
   logic [15:0] m_data_in = '0;
   logic [15:0] m_data_out;
   logic        m_access;
   logic        m_ack = 1'b0;
   logic        m_wr_en;
   logic [1:0]  m_bytesel;

   int checks = 0;
   int failures = 0;

`ifdef DMA_WORD_MODE_EN
   localparam bit WORD_EN = 1'b1;
`else
   localparam bit WORD_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   dma_channel_engine #(.COUNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_dir(cfg_dir),
      .cfg_decrement(cfg_decrement), .cfg_autoinit(cfg_autoinit),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop),
`ifdef DMA_WORD_MODE_EN
      .cfg_word(cfg_word),
`endif
      .dreq(dreq), .dack(dack), .dev_rd_data(dev_rd_data), .dev_wr_data(dev_wr_data),
      .dev_strobe(dev_strobe), .tc(tc), .busy(busy), .m_addr(m_addr),
      .m_data_in(m_data_in), .m_data_out(m_data_out), .m_access(m_access),
      .m_ack(m_ack), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel)
   );

   typedef struct packed {
      logic [18:0] a;
      logic [1:0]  bs;
      logic        wr;
      logic [15:0] d;
   } txn_t;

   txn_t        txq[$];
   logic [15:0] stq[$];
   logic [15:0] usedq[$];
   bit          mon_en = 1'b1, ack_en = 1'b1, rand_delay = 1'b0, fixed_rd = 1'b0, dreq_rand = 1'b0;
   logic [15:0] fixed_rd_val = 16'h0000;
   int          fixed_delay = 0, cur_delay = 0, wait_cnt = 0, viol = 0, tc_cnt = 0;
   logic        prev_access = 1'b0;
   logic [37:0] prev_fields = '0, cur_fields;

   // Memory contents as seen by bus reads: a fixed function of the word address.
   function automatic logic [15:0] rd_fun(input logic [18:0] w);
      logic [18:0] t;
      t = w * 19'd7 + 19'h01234;
      return t[15:0] ^ 16'hA5C3;
   endfunction

   function automatic logic [19:0] exp_addr(input logic [19:0] base, input int i, input bit dec, input bit word);
      logic [19:0] b, off;
      b   = word ? {base[19:1], 1'b0} : base;
      off = 20'(i) * (word ? 20'd2 : 20'd1);
      return dec ? b - off : b + off;
   endfunction

   always @(negedge clk) begin
      cur_fields = {m_addr, m_bytesel, m_wr_en, m_data_out};
      if (mon_en) begin
         if (m_access && !prev_access) txq.push_back(txn_t'(cur_fields));
         if (m_access && prev_access && cur_fields != prev_fields) viol++;
         if (!m_access && prev_access && !m_ack) viol++;
         if (dev_strobe) begin
            stq.push_back(dev_wr_data);
            usedq.push_back(dev_rd_data);
            dev_rd_data = 16'($urandom);
         end
         if (tc) tc_cnt++;
      end
      prev_access = m_access;
      prev_fields = cur_fields;
      if (m_ack) begin
         m_ack = 1'b0;
      end else if (m_access && ack_en) begin
         if (wait_cnt >= cur_delay) begin
            m_ack     = 1'b1;
            m_data_in = fixed_rd ? fixed_rd_val : rd_fun(m_addr);
            wait_cnt  = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
         end else begin
            wait_cnt++;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      txq.delete();
      stq.delete();
      usedq.delete();
      viol = 0;
      tc_cnt = 0;
      wait_cnt = 0;
      cur_delay = fixed_delay;
   endtask

   task automatic start_ch(input logic [19:0] a, input logic [15:0] c, input bit dir, input bit dec,
                           input bit auto, input bit word);
      cfg_addr = a; cfg_count = c; cfg_dir = dir; cfg_decrement = dec;
      cfg_autoinit = auto; cfg_word = word; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (dreq_rand) dreq = 1'($urandom_range(0, 1));
         step();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({dack, dev_wr_data, dev_strobe, tc, busy, m_addr, m_data_out, m_access, m_wr_en, m_bytesel} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b acc=%b addr=%h expected all zero", busy, m_access, m_addr);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_start_stop();
      cfg_start = 1'b1; cfg_stop = 1'b1;
      step();
      cfg_start = 1'b0; cfg_stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL start_with_stop busy=%b expected 0", busy); end
      start_ch(20'h00400, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL start_sets_busy busy=%b expected 1", busy); end
      dreq = 1'b1; cfg_stop = 1'b1;
      step();
      dreq = 1'b0; cfg_stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || m_access !== 1'b0) begin
         failures++; $display("FAIL stop_in_wait busy=%b acc=%b expected 0 0", busy, m_access);
      end
      step();
   endtask

   task automatic test_dev_to_mem();
      bit ok;
      logic [19:0] ea;
      logic [15:0] expd;
      fixed_delay = 0; rand_delay = 1'b0; fixed_rd = 1'b0;
      clear_mon();
      dreq = 1'b1;
      start_ch(20'h12345, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cfg_addr = 20'hABCDE; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      wait_idle(ok);
      dreq = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL d2m_timeout busy=%b expected 0", busy); end
      checks++;
      if (txq.size() != 3) begin failures++; $display("FAIL d2m_count got=%0d expected=3", txq.size()); end
      checks++;
      if (txq.size() > 0 && txq[0].a !== 19'h091A2) begin
         failures++; $display("FAIL d2m_first_addr got=%h expected=091a2", txq[0].a);
      end
      for (int i = 0; i < 3 && i < txq.size() && i < usedq.size(); i++) begin
         ea   = exp_addr(20'h12345, i, 1'b0, 1'b0);
         expd = {usedq[i][7:0], usedq[i][7:0]};
         checks++;
         if (txq[i].a !== ea[19:1] || txq[i].bs !== (ea[0] ? 2'b10 : 2'b01) || txq[i].wr !== 1'b1 || txq[i].d !== expd) begin
            failures++;
            $display("FAIL d2m_txn%0d got a=%h bs=%b wr=%b d=%h expected a=%h bs=%b wr=1 d=%h", i,
                     txq[i].a, txq[i].bs, txq[i].wr, txq[i].d, ea[19:1], (ea[0] ? 2'b10 : 2'b01), expd);
         end
      end
      checks++;
      if (tc_cnt != 1 || viol != 0 || stq.size() != 3 || dack !== 1'b0) begin
         failures++; $display("FAIL d2m_misc tc=%0d viol=%0d strobes=%0d dack=%b expected 1 0 3 0", tc_cnt, viol, stq.size(), dack);
      end
   endtask

   task automatic test_mem_to_dev_wrap();
      bit ok;
      logic [19:0] ea;
      logic [15:0] expd;
      fixed_rd = 1'b1; fixed_rd_val = 16'hBEEF;
      clear_mon();
      dreq = 1'b1;
      start_ch(20'h00001, 16'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_idle(ok);
      dreq = 1'b0;
      checks++;
      if (!ok || txq.size() != 3 || stq.size() != 3) begin
         failures++; $display("FAIL m2d_count ok=%b txns=%0d strobes=%0d expected 1 3 3", ok, txq.size(), stq.size());
      end
      for (int i = 0; i < 3 && i < txq.size() && i < stq.size(); i++) begin
         ea   = exp_addr(20'h00001, i, 1'b1, 1'b0);
         expd = {8'h00, (ea[0] ? 8'hBE : 8'hEF)};
         checks++;
         if (txq[i].a !== ea[19:1] || txq[i].bs !== (ea[0] ? 2'b10 : 2'b01) || txq[i].wr !== 1'b0 || stq[i] !== expd) begin
            failures++;
            $display("FAIL m2d_txn%0d got a=%h bs=%b wr=%b dev=%h expected a=%h dev=%h", i,
                     txq[i].a, txq[i].bs, txq[i].wr, stq[i], ea[19:1], expd);
         end
      end
      checks++;
      if (txq.size() == 3 && (txq[2].a !== 19'h7FFFF || txq[2].bs !== 2'b10)) begin
         failures++; $display("FAIL m2d_wrap got a=%h bs=%b expected 7ffff 10", txq[2].a, txq[2].bs);
      end
      checks++;
      if (tc_cnt != 1 || viol != 0) begin failures++; $display("FAIL m2d_tc tc=%0d viol=%0d expected 1 0", tc_cnt, viol); end
      fixed_rd = 1'b0;
   endtask

   task automatic test_stop_in_bus();
      bit ok;
      fixed_delay = 5;
      clear_mon();
      dreq = 1'b1;
      start_ch(20'h00200, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         if (m_access) break;
         step();
      end
      dreq = 1'b0;
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      checks++;
      if (m_access !== 1'b1) begin failures++; $display("FAIL stop_bus_hold acc=%b expected 1", m_access); end
      wait_idle(ok);
      checks++;
      if (!ok || txq.size() != 1 || tc_cnt != 0 || viol != 0 || dack !== 1'b0 || m_access !== 1'b0) begin
         failures++;
         $display("FAIL stop_bus_end ok=%b txns=%0d tc=%0d viol=%0d dack=%b acc=%b expected 1 1 0 0 0 0",
                  ok, txq.size(), tc_cnt, viol, dack, m_access);
      end
      fixed_delay = 0;
      clear_mon();
   endtask

   task automatic test_autoinit();
      logic [19:0] a;
      a = 20'($urandom);
      clear_mon();
      dreq = 1'b0;
      start_ch(a, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int p = 0; p < 2; p++) begin
         dreq = 1'b1;
         step();
         dreq = 1'b0;
         repeat (8) step();
      end
      checks++;
      if (txq.size() != 2 || tc_cnt != 2 || busy !== 1'b1) begin
         failures++; $display("FAIL autoinit_run txns=%0d tc=%0d busy=%b expected 2 2 1", txq.size(), tc_cnt, busy);
      end
      for (int i = 0; i < 2 && i < txq.size(); i++) begin
         checks++;
         if (txq[i].a !== a[19:1] || txq[i].bs !== (a[0] ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL autoinit_addr%0d got a=%h bs=%b expected a=%h", i, txq[i].a, txq[i].bs, a[19:1]);
         end
      end
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL autoinit_stop busy=%b expected 0", busy); end
   endtask

`ifdef DMA_WORD_MODE_EN
   task automatic test_word();
      bit ok;
      logic [19:0] ea;
      for (int dir = 0; dir < 2; dir++) begin
         clear_mon();
         dreq = 1'b1;
         start_ch(20'h00101, 16'd1, 1'(dir), 1'b0, 1'b0, 1'b1);
         wait_idle(ok);
         dreq = 1'b0;
         checks++;
         if (!ok || txq.size() != 2 || stq.size() != 2 || tc_cnt != 1) begin
            failures++; $display("FAIL word_count dir=%0d txns=%0d tc=%0d expected 2 1", dir, txq.size(), tc_cnt);
         end
         for (int i = 0; i < 2 && i < txq.size() && i < stq.size() && i < usedq.size(); i++) begin
            ea = exp_addr(20'h00101, i, 1'b0, 1'b1);
            checks++;
            if (txq[i].a !== ea[19:1] || txq[i].bs !== 2'b11 ||
                (dir == 0 && txq[i].d !== usedq[i]) || (dir == 1 && stq[i] !== rd_fun(ea[19:1]))) begin
               failures++;
               $display("FAIL word_txn%0d dir=%0d got a=%h bs=%b d=%h dev=%h expected a=%h bs=11", i, dir,
                        txq[i].a, txq[i].bs, txq[i].d, stq[i], ea[19:1]);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      bit ok, dir, dec, word;
      logic [19:0] a, ea;
      logic [15:0] expd, rd;
      int n;
      rand_delay = 1'b1; dreq_rand = 1'b1;
      for (int it = 0; it < 8; it++) begin
         case ($urandom_range(0, 2))
            0:       a = 20'hFFFFD;
            1:       a = 20'h00002;
            default: a = 20'($urandom);
         endcase
         n    = int'($urandom_range(1, 6));
         dir  = 1'($urandom_range(0, 1));
         dec  = 1'($urandom_range(0, 1));
         word = WORD_EN && ($urandom_range(0, 1) == 1);
         clear_mon();
         start_ch(a, 16'(n - 1), dir, dec, 1'b0, word);
         wait_idle(ok);
         dreq = 1'b0;
         checks++;
         if (!ok || txq.size() != n || stq.size() != n || tc_cnt != 1 || viol != 0) begin
            failures++;
            $display("FAIL rand%0d_summary ok=%b txns=%0d strobes=%0d tc=%0d viol=%0d expected n=%0d tc=1 viol=0",
                     it, ok, txq.size(), stq.size(), tc_cnt, viol, n);
         end
         for (int i = 0; i < n && i < txq.size() && i < stq.size() && i < usedq.size(); i++) begin
            ea   = exp_addr(a, i, dec, word);
            rd   = rd_fun(ea[19:1]);
            expd = dir ? (word ? rd : {8'h00, (ea[0] ? rd[15:8] : rd[7:0])})
                       : (word ? usedq[i] : {usedq[i][7:0], usedq[i][7:0]});
            checks++;
            if (txq[i].a !== ea[19:1] || txq[i].bs !== (word ? 2'b11 : (ea[0] ? 2'b10 : 2'b01)) ||
                txq[i].wr !== !dir || (dir ? stq[i] : txq[i].d) !== expd) begin
               failures++;
               $display("FAIL rand%0d_txn%0d got a=%h bs=%b wr=%b d=%h dev=%h expected a=%h data=%h", it, i,
                        txq[i].a, txq[i].bs, txq[i].wr, txq[i].d, stq[i], ea[19:1], expd);
            end
         end
      end
      rand_delay = 1'b0; dreq_rand = 1'b0;
   endtask

   task automatic test_reset_mid_bus();
      mon_en = 1'b0; ack_en = 1'b0;
      dreq = 1'b1;
      start_ch(20'h12345, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         if (m_access) break;
         step();
      end
      dreq = 1'b0;
      checks++;
      if (m_access !== 1'b1) begin failures++; $display("FAIL midbus_access acc=%b expected 1", m_access); end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++;
      if ({dack, dev_wr_data, dev_strobe, tc, busy, m_addr, m_data_out, m_access, m_wr_en, m_bytesel} !== '0) begin
         failures++; $display("FAIL midbus_reset busy=%b acc=%b dack=%b expected all zero", busy, m_access, dack);
      end
      step();
      checks++;
      if (busy !== 1'b0 || m_access !== 1'b0) begin
         failures++; $display("FAIL midbus_after busy=%b acc=%b expected 0 0", busy, m_access);
      end
      ack_en = 1'b1; mon_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_start_stop();
      test_dev_to_mem();
      test_mem_to_dev_wrap();
      test_stop_in_bus();
      test_autoinit();
`ifdef DMA_WORD_MODE_EN
      test_word();
`endif
      test_random();
      test_reset_mid_bus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
